// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and fetch-priority enum
//
// Purpose: constants and types shared by stage1_fetch and the later pipeline
// buffers (stage3+ reuse fetch_op_e for their own hold/advance decisions).
// Ports: none (package).

package pipe_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Priority order of a pipeline register update: redirect beats hold beats advance.
  typedef enum logic [1:0] {
    FETCH_REDIRECT = 2'd0,
    FETCH_HOLD     = 2'd1,
    FETCH_ADVANCE  = 2'd2
  } fetch_op_e;

endpackage

// File: rtl/stage1_fetch_if_id_buffer.sv
// rtl/stage1_fetch_if_id_buffer.sv - IF/ID instruction/pc register pair
//
// Purpose: captures the fetched instruction and its pc for stage2.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : 1 = capture instr_in/pc_in this edge, 0 = hold
//   instr_in     : instruction word from IMEM
//   pc_in        : pc the word was fetched from
//   instr, pc    : registered IF/ID contents (reset to NOP_INSTR / 0)

module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEFAULT,
  parameter logic [31:0] NOP_VALUE = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_VALUE;
      pc    <= '0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/stage1_fetch.sv
// rtl/stage1_fetch.sv - RV32I instruction-fetch stage (pc, IF/ID buffer, squash-state flop)
//
// Purpose: owns the pc, drives the IMEM address, fills the IF/ID buffer and
// registers the branch-squash state computed by stage2.
// Optional feature: define STAGE1_PERF_CNT_EN to add fetch/stall/redirect counters.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   stall             : 1 = run, 0 = load-use hold from stage2
//   branch_taken      : redirect request from EX
//   branch_target     : redirect pc (low two bits ignored)
//   next_state1       : squash-state next value from stage2
//   imem_rdata        : combinational IMEM read data for imem_addr
//   imem_addr         : current pc
//   if_id_instr       : IF/ID instruction to stage2
//   if_id_pc          : pc of if_id_instr
//   state1            : registered squash state to stage2
//   perf_*_cnt        : (STAGE1_PERF_CNT_EN only) wrapping event counters

module stage1_fetch
  import pipe_pkg::*;
#(
  parameter int            XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0],
  parameter logic [31:0]   NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            next_state1,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            state1
`ifdef STAGE1_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt,
  output logic [XLEN-1:0] perf_redirect_cnt
`endif
);

  logic [XLEN-1:0] pc;
  fetch_op_e       op;

  // Redirect beats the hazard hold so a taken branch is never lost to a stall.
  always_comb begin
    op = FETCH_ADVANCE;
    if (branch_taken)  op = FETCH_REDIRECT;
    else if (!stall)   op = FETCH_HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      case (op)
        FETCH_REDIRECT: pc <= {branch_target[XLEN-1:2], 2'b00};
        FETCH_ADVANCE:  pc <= pc + PC_INCR[XLEN-1:0];
        default:        pc <= pc;
      endcase
    end
  end

  // Squash state follows stage2 every cycle, regardless of hold or redirect.
  always_ff @(posedge clk) begin
    if (reset) state1 <= 1'b0;
    else       state1 <= next_state1;
  end

  assign imem_addr = pc;

  // The wrong-path words are still loaded on a redirect; stage2 squashes them.
  if_id_buffer #(
    .XLEN      (XLEN),
    .NOP_VALUE (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (op != FETCH_HOLD),
    .instr_in (imem_rdata),
    .pc_in    (pc),
    .instr    (if_id_instr),
    .pc       (if_id_pc)
  );

`ifdef STAGE1_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt    <= '0;
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (op == FETCH_ADVANCE)  perf_fetch_cnt    <= perf_fetch_cnt + 1'b1;
      if (op == FETCH_HOLD)     perf_stall_cnt    <= perf_stall_cnt + 1'b1;
      if (op == FETCH_REDIRECT) perf_redirect_cnt <= perf_redirect_cnt + 1'b1;
    end
  end
`endif

endmodule
